// File: rtl/hub75_pkg.sv
// Shared types and helpers for the HUB75 scan controller: FSM states, the
// layout of the packed frame-buffer word and the frame-buffer address width.
package hub75_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREFETCH,
    S_SHIFT,
    S_LATCH,
    S_DISPLAY
  } state_e;

  // fb_data packs {r0,g0,b0,r1,g1,b1}, r0 in the most significant field.
  typedef enum logic [2:0] {
    F_R0,
    F_G0,
    F_B0,
    F_R1,
    F_G1,
    F_B1
  } field_e;

  localparam int NUM_FIELDS = 6;

  function automatic int field_lsb(input field_e f, input int depth);
    return (NUM_FIELDS - 1 - int'(f)) * depth;
  endfunction

  function automatic int fb_addr_w(input int cols, input int rows);
    return $clog2(rows / 2) + $clog2(cols);
  endfunction

endpackage

// File: rtl/hub75_scan_ctrl_if.sv
// Frame-buffer read port: strobe plus {row_pair, col} address out, pixel word
// back exactly one cycle after the strobe.
interface hub75_scan_ctrl_if #(
  parameter int AW = 6,
  parameter int DW = 24
);
  logic          fb_rd;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_data;

  modport master (output fb_rd, output fb_addr, input fb_data);
  modport slave  (input fb_rd, input fb_addr, output fb_data);
endinterface

// File: rtl/hub75_on_timer.sv
// Loadable down-counter timing the DISPLAY window; done is high on the last
// cycle of a window of 'value' cycles that starts the cycle after load.
module hub75_on_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= value - 1'b1;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 scan controller: prefetch, shift, latch and BCM-timed display per row pair.
// Define HUB75_BCM_EN for DEPTH bit planes per row; otherwise only the MSB plane is shown.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS    = 64,
  parameter int ROWS    = 32,
  parameter int DEPTH   = 4,
  parameter int CLK_DIV = 2,
  parameter int BASE_ON = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  hub75_scan_ctrl_if.master          fb,
  output logic                       R0in,
  output logic                       G0in,
  output logic                       B0in,
  output logic                       R1in,
  output logic                       G1in,
  output logic                       B1in,
  output logic [$clog2(ROWS/2)-1:0]  Ain,
  output logic                       SCLKin,
  output logic                       LATCHin,
  output logic                       BLANKin,
  output logic                       frame_done
);
  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS / 2);
  localparam int SW = $clog2(2 * CLK_DIV);
  localparam int DW = NUM_FIELDS * DEPTH;
  localparam int AW = fb_addr_w(COLS, ROWS);
  localparam int TW = $clog2((BASE_ON << (DEPTH - 1)) + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS / 2 - 1);
  localparam logic [SW-1:0] SUB_CAP  = SW'(1);
  localparam logic [SW-1:0] SUB_HI   = SW'(CLK_DIV);
  localparam logic [SW-1:0] SUB_LAST = SW'(2 * CLK_DIV - 1);

  localparam int P_R0 = field_lsb(F_R0, DEPTH);
  localparam int P_G0 = field_lsb(F_G0, DEPTH);
  localparam int P_B0 = field_lsb(F_B0, DEPTH);
  localparam int P_R1 = field_lsb(F_R1, DEPTH);
  localparam int P_G1 = field_lsb(F_G1, DEPTH);
  localparam int P_B1 = field_lsb(F_B1, DEPTH);

  state_e           state, state_n;
  logic [SW-1:0]    sub, sub_n;
  logic [CW-1:0]    col, col_n;
  logic [RW-1:0]    row, row_n;
  logic             rd_c, capture, load_px, tmr_load, tmr_done, plane_last;
  logic [DW-1:0]    hold, src;
  logic [5:0]       px, px_n;
  logic [DEPTH-1:0] bit_mask;
  logic [TW-1:0]    on_val;

`ifdef HUB75_BCM_EN
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] PLANE_LAST = PW'(DEPTH - 1);
  logic [PW-1:0] plane, plane_n;

  assign bit_mask   = DEPTH'(1) << plane;
  assign on_val     = TW'(BASE_ON) << plane;
  assign plane_last = (plane == PLANE_LAST);
`else
  assign bit_mask   = DEPTH'(1) << (DEPTH - 1);
  assign on_val     = TW'(BASE_ON);
  assign plane_last = 1'b1;
`endif

  hub75_on_timer #(.W(TW)) u_on_timer (
    .clk   (clk),
    .rst   (rst),
    .load  (tmr_load),
    .value (on_val),
    .done  (tmr_done)
  );

  // Slot 0 loads straight from the read port since its word arrives on the same edge.
  always_comb begin
    src  = (state == S_PREFETCH) ? fb.fb_data : hold;
    px_n = {|(src[P_R0 +: DEPTH] & bit_mask), |(src[P_G0 +: DEPTH] & bit_mask),
            |(src[P_B0 +: DEPTH] & bit_mask), |(src[P_R1 +: DEPTH] & bit_mask),
            |(src[P_G1 +: DEPTH] & bit_mask), |(src[P_B1 +: DEPTH] & bit_mask)};
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_n  = state;
    sub_n    = sub + 1'b1;
    col_n    = col;
    row_n    = row;
`ifdef HUB75_BCM_EN
    plane_n  = plane;
`endif
    rd_c     = 1'b0;
    capture  = 1'b0;
    load_px  = 1'b0;
    tmr_load = 1'b0;

    unique case (state)
      S_IDLE: begin
        sub_n = '0;
        col_n = '0;
        row_n = '0;
`ifdef HUB75_BCM_EN
        plane_n = '0;
`endif
        if (enable) state_n = S_PREFETCH;
      end
      S_PREFETCH: begin
        if (sub == '0) begin
          rd_c = 1'b1;
        end else begin
          capture = 1'b1;
          load_px = 1'b1;
          state_n = S_SHIFT;
          sub_n   = '0;
          col_n   = '0;
        end
      end
      S_SHIFT: begin
        if (sub == '0 && col != COL_LAST) rd_c = 1'b1;
        if (sub == SUB_CAP && col != COL_LAST) capture = 1'b1;
        if (sub == SUB_LAST) begin
          sub_n = '0;
          if (col == COL_LAST) begin
            state_n = S_LATCH;
            col_n   = '0;
          end else begin
            col_n   = col + 1'b1;
            load_px = 1'b1;
          end
        end
      end
      S_LATCH: begin
        if (sub != '0) begin
          state_n  = S_DISPLAY;
          sub_n    = '0;
          tmr_load = 1'b1;
        end
      end
      S_DISPLAY: begin
        sub_n = '0;
        if (tmr_done) begin
`ifdef HUB75_BCM_EN
          plane_n = plane_last ? '0 : plane + 1'b1;
`endif
          if (plane_last) row_n = (row == ROW_LAST) ? '0 : row + 1'b1;
          if (enable) begin
            state_n = S_PREFETCH;
          end else begin
            state_n = S_IDLE;
            row_n   = '0;
`ifdef HUB75_BCM_EN
            plane_n = '0;
`endif
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      sub     <= '0;
      col     <= '0;
      row     <= '0;
`ifdef HUB75_BCM_EN
      plane   <= '0;
`endif
      hold    <= '0;
      px      <= '0;
      Ain     <= '0;
      SCLKin  <= 1'b0;
      LATCHin <= 1'b0;
      BLANKin <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state   <= state_n;
      sub     <= sub_n;
      col     <= col_n;
      row     <= row_n;
`ifdef HUB75_BCM_EN
      plane   <= plane_n;
`endif
      if (capture) hold <= fb.fb_data;
      if (load_px) px <= px_n;
      if (state_n == S_LATCH && state != S_LATCH) Ain <= row;
      // Panel strobes come from the next state so they leave a flop glitch-free.
      SCLKin  <= (state_n == S_SHIFT) && (sub_n >= SUB_HI);
      LATCHin <= (state_n == S_LATCH);
      BLANKin <= (state_n != S_DISPLAY);
    end
  end

  assign fb.fb_rd   = rd_c;
  assign fb.fb_addr = (state == S_SHIFT) ? AW'({row, CW'(col + 1'b1)}) : AW'({row, col});
  assign {R0in, G0in, B0in, R1in, G1in, B1in} = px;
  assign frame_done = (state == S_DISPLAY) && tmr_done && plane_last && (row == ROW_LAST);

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Directed bench for hub75_scan_ctrl (COLS=4, ROWS=4, DEPTH=2, CLK_DIV=2, BASE_ON=8);
// expectations follow whether HUB75_BCM_EN is defined for the build.
module tb_hub75_scan_ctrl;
  import hub75_pkg::*;

  localparam int COLS = 4, ROWS = 4, DEPTH = 2, CLK_DIV = 2, BASE_ON = 8;
  localparam int AW = fb_addr_w(COLS, ROWS);
  localparam int DW = 6 * DEPTH;
  localparam int RW = $clog2(ROWS / 2);
`ifdef HUB75_BCM_EN
  localparam bit BCM = 1'b1;
`else
  localparam bit BCM = 1'b0;
`endif
  localparam int FRAME = BCM ? 128 : 56;
  localparam int TRACE = 270;
  localparam int L2 = BCM ? 82 : 74;
  localparam int L3 = BCM ? 110 : 102;

  logic clk = 1'b0;
  logic rst, enable;
  logic R0in, G0in, B0in, R1in, G1in, B1in, SCLKin, LATCHin, BLANKin, frame_done;
  logic [RW-1:0] Ain;

  hub75_scan_ctrl_if #(.AW(AW), .DW(DW)) fb ();

  hub75_scan_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .DEPTH(DEPTH), .CLK_DIV(CLK_DIV), .BASE_ON(BASE_ON)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .fb(fb),
    .R0in(R0in), .G0in(G0in), .B0in(B0in), .R1in(R1in), .G1in(G1in), .B1in(B1in),
    .Ain(Ain), .SCLKin(SCLKin), .LATCHin(LATCHin), .BLANKin(BLANKin),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Frame-buffer model: word appears one cycle after the read strobe.
  logic [DW-1:0] mem [0:7];
  always @(posedge clk) if (fb.fb_rd) fb.fb_data <= mem[fb.fb_addr];

  logic [5:0]    t_px    [TRACE];
  logic          t_rd    [TRACE];
  logic [AW-1:0] t_addr  [TRACE];
  logic          t_sclk  [TRACE];
  logic          t_latch [TRACE];
  logic          t_blank [TRACE];
  logic          t_fd    [TRACE];
  logic [RW-1:0] t_ain   [TRACE];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_pins"},  {R0in, G0in, B0in, R1in, G1in, B1in}, 0);
    check({tag, "_sclk"},  SCLKin, 0);
    check({tag, "_latch"}, LATCHin, 0);
    check({tag, "_blank"}, BLANKin, 1);
    check({tag, "_ain"},   Ain, 0);
    check({tag, "_rd"},    fb.fb_rd, 0);
    check({tag, "_addr"},  fb.fb_addr, 0);
    check({tag, "_fdone"}, frame_done, 0);
  endtask

  // Samples cycle k on the falling edge; optionally drops enable after cycle drop_at.
  task automatic record(input int n, input int drop_at);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      t_px[k]    = {R0in, G0in, B0in, R1in, G1in, B1in};
      t_rd[k]    = fb.fb_rd;
      t_addr[k]  = fb.fb_addr;
      t_sclk[k]  = SCLKin;
      t_latch[k] = LATCHin;
      t_blank[k] = BLANKin;
      t_fd[k]    = frame_done;
      t_ain[k]   = Ain;
      if (k == drop_at) enable = 1'b0;
    end
  endtask

  function automatic int cnt_blank_lo(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (t_blank[k] === 1'b0) n++;
    return n;
  endfunction

  function automatic int cnt_sclk_hi(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (t_sclk[k] === 1'b1) n++;
    return n;
  endfunction

  function automatic int cnt_sclk_rise(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++)
      if (k > 0 && t_sclk[k] === 1'b1 && t_sclk[k-1] === 1'b0) n++;
    return n;
  endfunction

  function automatic int cnt_rd(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (t_rd[k] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int cnt_fd(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++) if (t_fd[k] !== 1'b0) n++;
    return n;
  endfunction

  function automatic int cnt_latch_bad(input int a, input int b);
    int n = 0;
    for (int k = a; k <= b; k++)
      if (t_latch[k] === 1'b1 && (t_sclk[k] !== 1'b0 || t_blank[k] !== 1'b1)) n++;
    return n;
  endfunction

  initial begin
    // Columns 0..3 of row pair 0; row pair 1 holds the same words.
    mem[0] = 12'h555;  // every field 2'b01
    mem[1] = 12'h9C9;  // r0=10 g0=01 b0=11 r1=00 g1=10 b1=01
    mem[2] = 12'h000;
    mem[3] = 12'hFFF;
    for (int i = 0; i < 4; i++) mem[4+i] = mem[i];

    rst = 1'b1;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    rst = 1'b0;
    @(negedge clk);
    check("idle_blank", BLANKin, 1);
    check("idle_no_rd", fb.fb_rd, 0);

    // Continuous scan over two frames.
    enable = 1'b1;
    record(TRACE, -1);
    check("first_rd", t_rd[0], 1);
    check("first_addr", t_addr[0], 0);
    check("blank_until_display", cnt_blank_lo(0, 19), 0);
    check("blank_low_k20", t_blank[20], 0);
    check("sclk_rises_row0", cnt_sclk_rise(0, 19), 4);
    check("sclk_high_cycles", cnt_sclk_hi(0, 19), 8);
    check("sclk_slot0", {t_sclk[2], t_sclk[3], t_sclk[4], t_sclk[5]}, 4'b0011);
    check("latch_window", {t_latch[17], t_latch[18], t_latch[19], t_latch[20]}, 4'b0110);
    check("rd_count_period0", cnt_rd(0, 27), 4);
    check("display_len_p0", cnt_blank_lo(0, 27), 8);
    check("display_len_p1", cnt_blank_lo(28, 63), BCM ? 16 : 8);
    check("period1_rd", t_rd[28], 1);
    check("period1_addr", t_addr[28], BCM ? 0 : 4);
    check("period2_rd", t_rd[BCM ? 64 : 56], 1);
    check("period2_addr", t_addr[BCM ? 64 : 56], BCM ? 4 : 0);
    check("pins_slot0", t_px[2], BCM ? 6'h3F : 6'h00);
    check("pins_slot1_start", t_px[6], BCM ? 6'b011001 : 6'b101010);
    check("pins_slot1_end", t_px[9], BCM ? 6'b011001 : 6'b101010);
    check("pins_slot2", t_px[10], 6'h00);
    check("pins_slot3", t_px[14], 6'h3F);
    check("r0_p0_slot1", t_px[6][5], BCM ? 0 : 1);
    check("r0_p1_slot1", t_px[34][5], 1);
    check("pins_p1_slot1_end", t_px[37], 6'b101010);
    check("latch_points", {t_latch[18], t_latch[46], t_latch[L2], t_latch[L3]}, 4'hF);
    check("ain_sequence", {t_ain[18], t_ain[46], t_ain[L2], t_ain[L3]}, BCM ? 4'b0011 : 4'b0101);
    check("fdone_frame1", t_fd[FRAME-1], 1);
    check("fdone_frame2", t_fd[2*FRAME-1], 1);
    check("fdone_count", cnt_fd(0, 2*FRAME-1), 2);
    check("latch_overlap", cnt_latch_bad(0, TRACE-1), 0);

    // Drop enable during the second scan period's shift; that period must finish.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    enable = 1'b1;
    record(120, 32);
    check("drop_display_len", cnt_blank_lo(32, BCM ? 63 : 55), BCM ? 16 : 8);
    check("drop_last_display", t_blank[BCM ? 63 : 55], 0);
    check("drop_idle_blank", cnt_blank_lo(BCM ? 64 : 56, 119), 0);
    check("drop_no_rd", cnt_rd(BCM ? 64 : 56, 119), 0);
    check("drop_no_sclk", cnt_sclk_hi(BCM ? 64 : 56, 119), 0);

    // Restart from IDLE, then reset in the middle of a shift.
    enable = 1'b1;
    record(101, -1);
    check("restart_rd", t_rd[0], 1);
    check("restart_addr", t_addr[0], 0);
    check("pre_reset_pins", t_px[100], BCM ? 6'b101010 : 6'h3F);
    rst = 1'b1;
    @(negedge clk);
    check_reset("midshift_reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_rd", fb.fb_rd, 1);
    check("post_reset_addr", fb.fb_addr, 0);
    check("post_reset_blank", BLANKin, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
